// File: rtl/telemetry_frame_sequencer_pkg.sv
// Shared encodings for the IAGC telemetry logger path: status codes, frame layout
// and the frame sequencer state type.
package telemetry_frame_sequencer_pkg;

  localparam logic [3:0]  IAGC_STATUS_RESET = 4'b0000;
  localparam logic [3:0]  IAGC_STATUS_INIT  = 4'b0001;
  localparam logic [3:0]  IAGC_STATUS_RUN   = 4'b1111;

  localparam logic [7:0]  FRAME_HEADER = 8'hA5;
  localparam int unsigned FRAME_BYTES  = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT
  } frame_state_t;

endpackage

// File: rtl/period_ticker.sv
// Free-running period counter: one-cycle tick every TICKS cycles while enabled,
// held at zero while disabled.
module period_ticker #(
  parameter int unsigned TICKS = 300000
) (
  input  logic i_clock,
  input  logic i_nReset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned  CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      count <= '0;
    end else if (!i_enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign o_tick = i_enable && (count == LAST);

endmodule

// File: rtl/telemetry_frame_sequencer.sv
// Periodically snapshots the IAGC observables and sends them as a 9-byte frame
// (header, 7 payload bytes, checksum) through a start/busy/done UART handshake.
module telemetry_frame_sequencer
  import telemetry_frame_sequencer_pkg::*;
#(
  parameter int unsigned TICKS               = 300000,
  parameter int unsigned AMPLITUDE_DATA_SIZE = 16,
  parameter int unsigned UART_DATA_SIZE      = 8,
  parameter int unsigned IAGC_STATUS_SIZE    = 4,
  parameter logic [IAGC_STATUS_SIZE-1:0] RUN_STATUS  = IAGC_STATUS_RUN,
  parameter logic [UART_DATA_SIZE-1:0]   HEADER_BYTE = FRAME_HEADER
) (
  input  logic                           i_clock,
  input  logic                           i_nReset,
  input  logic [IAGC_STATUS_SIZE-1:0]    i_iagcStatus,
  input  logic [AMPLITUDE_DATA_SIZE-1:0] i_referenceAmplitude,
  input  logic [AMPLITUDE_DATA_SIZE-1:0] i_errorAmplitude,
  input  logic [UART_DATA_SIZE-1:0]      i_quotient,
  input  logic [UART_DATA_SIZE-1:0]      i_fractional,
  input  logic                           i_onPhase,
  input  logic                           i_txBusy,
  input  logic                           i_txDone,
  output logic [UART_DATA_SIZE-1:0]      o_txData,
  output logic                           o_txStart,
  output logic                           o_frameActive,
  output logic [15:0]                    o_frameCount,
  output logic                           o_overrun
);

  localparam int unsigned U          = UART_DATA_SIZE;
  localparam logic [3:0]  LAST_INDEX = 4'(FRAME_BYTES - 1);

  frame_state_t                   state;
  logic                           tick;
  logic [3:0]                     idx;
  logic [U-1:0]                   checksum;
  logic [U-1:0]                   cur_byte;
  logic [AMPLITUDE_DATA_SIZE-1:0] snap_ref;
  logic [AMPLITUDE_DATA_SIZE-1:0] snap_err;
  logic [U-1:0]                   snap_quo;
  logic [U-1:0]                   snap_frac;
  logic                           snap_phase;

  period_ticker #(
    .TICKS(TICKS)
  ) u_ticker (
    .i_clock (i_clock),
    .i_nReset(i_nReset),
    .i_enable(i_iagcStatus == RUN_STATUS),
    .o_tick  (tick)
  );

  // Amplitudes are sent low byte first.
  always_comb begin
    cur_byte = '0;
    case (idx)
      4'd0:    cur_byte = HEADER_BYTE;
      4'd1:    cur_byte = snap_ref[U-1:0];
      4'd2:    cur_byte = snap_ref[2*U-1:U];
      4'd3:    cur_byte = snap_err[U-1:0];
      4'd4:    cur_byte = snap_err[2*U-1:U];
      4'd5:    cur_byte = snap_quo;
      4'd6:    cur_byte = snap_frac;
      4'd7:    cur_byte = {{(U-1){1'b0}}, snap_phase};
      default: cur_byte = checksum;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      checksum      <= '0;
      snap_ref      <= '0;
      snap_err      <= '0;
      snap_quo      <= '0;
      snap_frac     <= '0;
      snap_phase    <= 1'b0;
      o_txData      <= '0;
      o_txStart     <= 1'b0;
      o_frameActive <= 1'b0;
      o_frameCount  <= '0;
      o_overrun     <= 1'b0;
    end else begin
      o_txStart <= 1'b0;
      // A tick arriving mid-frame is dropped, only flagged.
      if (tick && state != ST_IDLE) o_overrun <= 1'b1;
      case (state)
        ST_IDLE: if (tick) state <= ST_LOAD;
        ST_LOAD: begin
          snap_ref      <= i_referenceAmplitude;
          snap_err      <= i_errorAmplitude;
          snap_quo      <= i_quotient;
          snap_frac     <= i_fractional;
          snap_phase    <= i_onPhase;
          idx           <= '0;
          checksum      <= '0;
          o_frameActive <= 1'b1;
          state         <= ST_ISSUE;
        end
        ST_ISSUE: if (!i_txBusy) begin
          o_txData  <= cur_byte;
          o_txStart <= 1'b1;
          state     <= ST_WAIT;
        end
        ST_WAIT: if (i_txDone) begin
          if (idx == LAST_INDEX) begin
            o_frameActive <= 1'b0;
            o_frameCount  <= o_frameCount + 16'd1;
            state         <= ST_IDLE;
          end else begin
            if (idx != 4'd0) checksum <= checksum + cur_byte;
            idx   <= idx + 4'd1;
            state <= ST_ISSUE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_frame_sequencer.sv
// Bench for telemetry_frame_sequencer: table of frame vectors, a UART tx model that
// pops expected bytes from a scoreboard queue on every start, plus corner sequences.
module tb_telemetry_frame_sequencer;

  localparam int unsigned TICKS = 100;
  localparam logic [3:0]  ST_RESET = 4'b0000;
  localparam logic [3:0]  ST_INIT  = 4'b0001;
  localparam logic [3:0]  ST_RUN   = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  status;
  logic [15:0] ref_amp, err_amp;
  logic [7:0]  quo, frac;
  logic        phase;
  logic        tx_busy, tx_done;
  logic [7:0]  tx_data;
  logic        tx_start, frame_active, overrun;
  logic [15:0] frame_count;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned busy_len  = 3;
  int unsigned busy_cnt  = 0;
  int unsigned start_total = 0;
  logic [7:0]  byte_q[$];

  typedef struct {
    logic [15:0] ref_amp;
    logic [15:0] err_amp;
    logic [7:0]  quo;
    logic [7:0]  frac;
    logic        phase;
    int unsigned busy_len;
    logic [7:0]  csum;
    logic        exp_overrun;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  telemetry_frame_sequencer #(
    .TICKS(TICKS)
  ) dut (
    .i_clock             (clk),
    .i_nReset            (rst_n),
    .i_iagcStatus        (status),
    .i_referenceAmplitude(ref_amp),
    .i_errorAmplitude    (err_amp),
    .i_quotient          (quo),
    .i_fractional        (frac),
    .i_onPhase           (phase),
    .i_txBusy            (tx_busy),
    .i_txDone            (tx_done),
    .o_txData            (tx_data),
    .o_txStart           (tx_start),
    .o_frameActive       (frame_active),
    .o_frameCount        (frame_count),
    .o_overrun           (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // UART tx model: busy for busy_len cycles after each start, then a one-cycle done.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (!rst_n) begin
        tx_busy  = 1'b0;
        busy_cnt = 0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            tx_busy = 1'b0;
            tx_done = 1'b1;
          end
        end
        if (tx_start) begin
          start_total++;
          check("start_while_busy", {31'd0, tx_busy}, 32'd0);
          if (byte_q.size() == 0) begin
            check("unexpected_start", 32'd1, 32'd0);
          end else begin
            check("tx_byte", {24'd0, tx_data}, {24'd0, byte_q.pop_front()});
          end
          tx_busy  = 1'b1;
          busy_cnt = busy_len;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input vec_t v);
    byte_q.push_back(8'hA5);
    byte_q.push_back(v.ref_amp[7:0]);
    byte_q.push_back(v.ref_amp[15:8]);
    byte_q.push_back(v.err_amp[7:0]);
    byte_q.push_back(v.err_amp[15:8]);
    byte_q.push_back(v.quo);
    byte_q.push_back(v.frac);
    byte_q.push_back({7'd0, v.phase});
    byte_q.push_back(v.csum);
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    status = ST_INIT;
    cycles(3);
    byte_q.delete();
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic start_run(input vec_t v);
    ref_amp  = v.ref_amp;
    err_amp  = v.err_amp;
    quo      = v.quo;
    frac     = v.frac;
    phase    = v.phase;
    busy_len = v.busy_len;
    push_frame(v);
    @(posedge clk); #2;
    status = ST_RUN;
  endtask

  task automatic wait_count(input logic [15:0] exp);
    int unsigned n = 0;
    while (frame_count != exp && n < 5000) begin
      @(posedge clk); #2;
      n++;
    end
    status = ST_INIT;
    check("frame_count", {16'd0, frame_count}, {16'd0, exp});
  endtask

  task automatic wait_starts(input int unsigned target);
    int unsigned n = 0;
    while (start_total < target && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check("start_reached", {31'd0, start_total >= target}, 32'd1);
  endtask

  // First start is produced by the 101st edge after the edge that first samples RUN.
  task automatic run_frame(input vec_t v, input logic [15:0] exp_count);
    int unsigned n = 0;
    bit started = 0;
    start_run(v);
    while (n < 400 && !started) begin
      @(posedge clk); #2;
      n++;
      if (tx_start) started = 1;
    end
    check("start_latency", n - 1, 32'd101);
    wait_count(exp_count);
    check("frame_active_end", {31'd0, frame_active}, 32'd0);
    check("overrun", {31'd0, overrun}, {31'd0, v.exp_overrun});
    check("queue_drained", byte_q.size(), 32'd0);
  endtask

  initial begin
    int unsigned s0;
    int unsigned n;
    bit seen_active;

    //            ref       err       quo    frac   ph  busy csum   ov
    vecs[0] = '{16'h1234, 16'hABCD, 8'h7F, 8'h80, 1'b0, 3,  8'hBD, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 1'b1, 3,  8'hFB, 1'b0};
    vecs[2] = '{16'h8001, 16'h0180, 8'h01, 8'h02, 1'b0, 3,  8'h05, 1'b0};
    vecs[3] = '{16'h000F, 16'h00F0, 8'h50, 8'h05, 1'b1, 20, 8'h55, 1'b1};

    ref_amp = '0; err_amp = '0; quo = '0; frac = '0; phase = 1'b0;
    status  = ST_RESET;
    rst_n   = 1'b0;
    cycles(3);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_frame_active", {31'd0, frame_active}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;

    // Logging disabled: RESET then INIT status for 1000 cycles.
    s0 = start_total;
    seen_active = 0;
    for (int unsigned i = 0; i < 1000; i++) begin
      if (i == 500) status = ST_INIT;
      @(posedge clk); #2;
      if (frame_active) seen_active = 1;
    end
    check("disabled_no_start", start_total - s0, 32'd0);
    check("disabled_no_active", {31'd0, seen_active}, 32'd0);

    // Table-driven frames; frame count accumulates across vectors.
    for (int unsigned i = 0; i < 4; i++) begin
      run_frame(vecs[i], 16'(i + 1));
      cycles(5);
    end

    // Overrun: 150-cycle byte time against a 100-cycle period.
    do_reset();
    begin
      vec_t v = vecs[3];
      v.busy_len = 150;
      start_run(v);
    end
    n = 0;
    while (!overrun && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("overrun_in_frame", {31'd0, frame_active}, 32'd1);
    check("overrun_count_before", {16'd0, frame_count}, 32'd0);
    wait_count(16'd1);
    check("overrun_queue_drained", byte_q.size(), 32'd0);
    cycles(300);
    check("overrun_count_stable", {16'd0, frame_count}, 32'd1);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Inputs change to all-ones right after the snapshot.
    do_reset();
    start_run(vecs[0]);
    n = 0;
    while (!frame_active && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    check("snapshot_active", {31'd0, frame_active}, 32'd1);
    ref_amp = 16'hFFFF; err_amp = 16'hFFFF; quo = 8'hFF; frac = 8'hFF; phase = 1'b1;
    wait_count(16'd1);
    check("snapshot_queue_drained", byte_q.size(), 32'd0);

    // Status leaves RUN during byte 4: frame completes, nothing further.
    do_reset();
    s0 = start_total;
    begin
      vec_t v = vecs[2];
      v.busy_len = 10;
      start_run(v);
    end
    wait_starts(s0 + 5);
    status = ST_INIT;
    wait_count(16'd1);
    check("disable_queue_drained", byte_q.size(), 32'd0);
    s0 = start_total;
    cycles(500);
    check("disable_no_more_starts", start_total - s0, 32'd0);
    check("disable_count_stable", {16'd0, frame_count}, 32'd1);

    // Reset during byte 3, then a fresh frame from count 0.
    do_reset();
    s0 = start_total;
    begin
      vec_t v = vecs[1];
      v.busy_len = 10;
      start_run(v);
    end
    wait_starts(s0 + 4);
    rst_n  = 1'b0;
    status = ST_INIT;
    #1;
    check("abort_tx_data", {24'd0, tx_data}, 32'd0);
    check("abort_tx_start", {31'd0, tx_start}, 32'd0);
    check("abort_frame_active", {31'd0, frame_active}, 32'd0);
    check("abort_frame_count", {16'd0, frame_count}, 32'd0);
    check("abort_overrun", {31'd0, overrun}, 32'd0);
    cycles(3);
    byte_q.delete();
    rst_n = 1'b1;
    cycles(2);
    run_frame(vecs[3], 16'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
